rv32i_ctrl_fsm: RTL and testbench



---
 rtl/rv32i_ctrl_pkg.sv | 27 ++
 rtl/rv32i_mem_timer.sv | 35 +++
 rtl/rv32i_ctrl_fsm.sv | 161 ++++++++++++++++
 tb/tb_rv32i_ctrl_fsm.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control sequencer.
package rv32i_ctrl_pkg;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JAL    = 2'd2;
    localparam logic [1:0] PC_JALR   = 2'd3;

    localparam logic [1:0] WB_ALU    = 2'd0;
    localparam logic [1:0] WB_DR     = 2'd1;
    localparam logic [1:0] WB_PC4    = 2'd2;
    localparam logic [1:0] WB_IMM    = 2'd3;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd1;
    localparam logic [1:0] CAUSE_FETCH_TO = 2'd2;
    localparam logic [1:0] CAUSE_DATA_TO  = 2'd3;

endpackage

// File: rtl/rv32i_mem_timer.sv
// Bus-wait watchdog: counts cycles spent waiting for an ack and flags the
// last permitted wait cycle. MEM_TIMEOUT=0 disables it entirely.
module rv32i_mem_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic wait_i,
    input  logic ack_i,
    output logic expired_o
);

    generate
        if (MEM_TIMEOUT == 0) begin : g_off
            assign expired_o = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);
            logic [CW-1:0] cnt_q, cnt_d;

            // Any non-waiting cycle or an ack clears, so every FETCH/MEM entry starts at zero.
            always_comb begin
                cnt_d = '0;
                if (wait_i && !ack_i) cnt_d = cnt_q + 1'b1;
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) cnt_q <= '0;
                else       cnt_q <= cnt_d;
            end

            assign expired_o = wait_i && (cnt_q == CW'(MEM_TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/rv32i_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: fetch/decode/exec/mem/wb with
// bus-timeout trap, sticky halt/trap and a retired-instruction counter.
module rv32i_ctrl_fsm
    import rv32i_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned INSTRET_W   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 arr_i,
    input  logic                 ari_i,
    input  logic                 ld_i,
    input  logic                 st_i,
    input  logic                 br_i,
    input  logic                 jal_i,
    input  logic                 jalr_i,
    input  logic                 lui_i,
    input  logic                 auipc_i,
    input  logic                 ebc_i,
    input  logic [4:0]           rd_i,
    input  logic                 br_taken_i,
    input  logic                 mem_ack_i,
    output logic                 mem_req_o,
    output logic                 mem_instr_o,
    output logic                 mem_we_o,
    output logic                 ir_we_o,
    output logic                 dr_we_o,
    output logic                 pc_we_o,
    output logic [1:0]           pc_sel_o,
    output logic                 alu_a_sel_o,
    output logic                 alu_b_sel_o,
    output logic                 rf_we_o,
    output logic [1:0]           wb_sel_o,
    output logic                 halted_o,
    output logic                 trap_o,
    output logic [1:0]           trap_cause_o,
    output logic [INSTRET_W-1:0] instret_o,
    output logic [2:0]           state_o
);

    logic [2:0]           state_q, state_d;
    logic [1:0]           cause_q, cause_d;
    logic [INSTRET_W-1:0] instret_q;
    logic                 retire, waiting, expired, any_op;

    assign any_op  = arr_i | ari_i | ld_i | st_i | br_i | jal_i | jalr_i | lui_i | auipc_i;
    assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);

    rv32i_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wait_i    (waiting),
        .ack_i     (mem_ack_i),
        .expired_o (expired)
    );

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        retire      = 1'b0;
        mem_req_o   = 1'b0;
        mem_instr_o = 1'b0;
        mem_we_o    = 1'b0;
        ir_we_o     = 1'b0;
        dr_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        pc_sel_o    = PC_PLUS4;
        alu_a_sel_o = 1'b0;
        alu_b_sel_o = 1'b0;
        rf_we_o     = 1'b0;
        wb_sel_o    = WB_ALU;
        halted_o    = 1'b0;
        trap_o      = 1'b0;
        // Reset masks every control output combinationally, dropping an in-flight request.
        if (!rst_i) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req_o   = 1'b1;
                    mem_instr_o = 1'b1;
                    if (mem_ack_i) begin
                        ir_we_o = 1'b1;
                        state_d = ST_DECODE;
                    end else if (expired) begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_FETCH_TO;
                    end
                end
                ST_DECODE: begin
                    if (ebc_i) begin
                        state_d = ST_HALT;
                    end else if (!any_op) begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    alu_a_sel_o = auipc_i | jal_i | br_i;
                    alu_b_sel_o = !arr_i;
                    if (br_i) begin
                        pc_we_o  = 1'b1;
                        pc_sel_o = br_taken_i ? PC_BRANCH : PC_PLUS4;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end else if (ld_i || st_i) begin
                        state_d = ST_MEM;
                    end else begin
                        state_d = ST_WB;
                    end
                end
                ST_MEM: begin
                    mem_req_o = 1'b1;
                    mem_we_o  = st_i;
                    if (mem_ack_i) begin
                        if (st_i) begin
                            pc_we_o = 1'b1;
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            dr_we_o = 1'b1;
                            state_d = ST_WB;
                        end
                    end else if (expired) begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_DATA_TO;
                    end
                end
                ST_WB: begin
                    rf_we_o  = (rd_i != 5'd0);
                    wb_sel_o = ld_i ? WB_DR : (jal_i || jalr_i) ? WB_PC4 : lui_i ? WB_IMM : WB_ALU;
                    pc_we_o  = 1'b1;
                    pc_sel_o = jal_i ? PC_JAL : jalr_i ? PC_JALR : PC_PLUS4;
                    retire   = 1'b1;
                    state_d  = ST_FETCH;
                end
                ST_HALT: halted_o = 1'b1;
                ST_TRAP: trap_o   = 1'b1;
                default: state_d  = ST_TRAP;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_FETCH;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (retire) instret_q <= instret_q + 1'b1;
        end
    end

    assign trap_cause_o = rst_i ? CAUSE_NONE : cause_q;
    assign instret_o    = rst_i ? '0 : instret_q;
    assign state_o      = rst_i ? '0 : state_q;

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// Self-checking bench for rv32i_ctrl_fsm: directed scenarios plus randomized
// instruction streams compared every cycle against a behavioural model.
module tb_rv32i_ctrl_fsm;

    localparam int TO = 4;
    localparam int I_ARR = 0, I_ARI = 1, I_LD = 2, I_ST = 3, I_BR = 4,
                   I_JAL = 5, I_JALR = 6, I_LUI = 7, I_AUIPC = 8, I_EBC = 9;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  fl;
    logic [4:0]  rd;
    logic        taken, ack;

    logic        mem_req_o, mem_instr_o, mem_we_o, ir_we_o, dr_we_o, pc_we_o;
    logic [1:0]  pc_sel_o, wb_sel_o, trap_cause_o;
    logic        alu_a_sel_o, alu_b_sel_o, rf_we_o, halted_o, trap_o;
    logic [31:0] instret_o;
    logic [2:0]  state_o;
    logic [51:0] dut_pack;

    int          checks = 0;
    int          errors = 0;

    int          m_st, m_cnt;
    logic [31:0] m_inst;
    logic [1:0]  m_cause;

    always #5 clk = ~clk;

    rv32i_ctrl_fsm #(.MEM_TIMEOUT(TO), .INSTRET_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .arr_i(fl[I_ARR]), .ari_i(fl[I_ARI]), .ld_i(fl[I_LD]), .st_i(fl[I_ST]),
        .br_i(fl[I_BR]), .jal_i(fl[I_JAL]), .jalr_i(fl[I_JALR]), .lui_i(fl[I_LUI]),
        .auipc_i(fl[I_AUIPC]), .ebc_i(fl[I_EBC]),
        .rd_i(rd), .br_taken_i(taken), .mem_ack_i(ack),
        .mem_req_o(mem_req_o), .mem_instr_o(mem_instr_o), .mem_we_o(mem_we_o),
        .ir_we_o(ir_we_o), .dr_we_o(dr_we_o), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o),
        .alu_a_sel_o(alu_a_sel_o), .alu_b_sel_o(alu_b_sel_o), .rf_we_o(rf_we_o),
        .wb_sel_o(wb_sel_o), .halted_o(halted_o), .trap_o(trap_o),
        .trap_cause_o(trap_cause_o), .instret_o(instret_o), .state_o(state_o)
    );

    assign dut_pack = {mem_req_o, mem_instr_o, mem_we_o, ir_we_o, dr_we_o, pc_we_o, pc_sel_o,
                       alu_a_sel_o, alu_b_sel_o, rf_we_o, wb_sel_o, halted_o, trap_o,
                       trap_cause_o, instret_o, state_o};

    // Expected outputs for the current cycle, from the instruction-class rules.
    function automatic logic [51:0] model_out();
        logic mreq, minstr, mwe, irwe, drwe, pcwe, aa, ab, rfwe, hal, trp;
        logic [1:0] pcs, wbs;
        mreq = 0; minstr = 0; mwe = 0; irwe = 0; drwe = 0; pcwe = 0;
        aa = 0; ab = 0; rfwe = 0; hal = 0; trp = 0; pcs = 0; wbs = 0;
        if (rst) return '0;
        case (m_st)
            0: begin mreq = 1; minstr = 1; irwe = ack; end
            2: begin
                aa = fl[I_AUIPC] | fl[I_JAL] | fl[I_BR];
                ab = !fl[I_ARR];
                if (fl[I_BR]) begin pcwe = 1; pcs = taken ? 2'd1 : 2'd0; end
            end
            3: begin
                mreq = 1; mwe = fl[I_ST];
                if (ack && fl[I_ST]) pcwe = 1;
                if (ack && fl[I_LD]) drwe = 1;
            end
            4: begin
                rfwe = (rd != 0);
                wbs  = fl[I_LD] ? 2'd1 : (fl[I_JAL] | fl[I_JALR]) ? 2'd2 : fl[I_LUI] ? 2'd3 : 2'd0;
                pcwe = 1;
                pcs  = fl[I_JAL] ? 2'd2 : fl[I_JALR] ? 2'd3 : 2'd0;
            end
            5: hal = 1;
            6: trp = 1;
            default: ;
        endcase
        return {mreq, minstr, mwe, irwe, drwe, pcwe, pcs, aa, ab, rfwe, wbs, hal, trp,
                m_cause, m_inst, 3'(m_st)};
    endfunction

    task automatic model_step();
        if (rst) begin
            m_st = 0; m_cnt = 0; m_inst = 0; m_cause = 0;
            return;
        end
        case (m_st)
            0: if (ack) begin m_st = 1; m_cnt = 0; end
               else if (m_cnt + 1 == TO) begin m_st = 6; m_cause = 2; m_cnt = 0; end
               else m_cnt++;
            1: if (fl[I_EBC]) m_st = 5;
               else if (fl[8:0] == 0) begin m_st = 6; m_cause = 1; end
               else m_st = 2;
            2: if (fl[I_BR]) begin m_inst++; m_st = 0; end
               else m_st = (fl[I_LD] | fl[I_ST]) ? 3 : 4;
            3: if (ack) begin
                   m_cnt = 0;
                   if (fl[I_ST]) begin m_inst++; m_st = 0; end else m_st = 4;
               end else if (m_cnt + 1 == TO) begin m_st = 6; m_cause = 3; m_cnt = 0; end
               else m_cnt++;
            4: begin m_inst++; m_st = 0; end
            default: ;
        endcase
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic settle();
        #1;
        chk("cycle_outputs", {12'd0, dut_pack}, {12'd0, model_out()});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic step(logic a, int exp_st, string nm);
        ack = a;
        settle();
        chk(nm, 64'(state_o), 64'(exp_st));
        tick();
    endtask

    task automatic set_op(int idx, logic [4:0] r);
        fl = '0;
        if (idx >= 0) fl[idx] = 1'b1;
        rd = r;
    endtask

    task automatic do_reset();
        rst = 1; ack = 0;
        settle();
        chk("reset_outputs_zero", {12'd0, dut_pack}, 64'd0);
        tick();
        rst = 0;
    endtask

    initial begin
        int stuck;
        int r;
        rst = 1; fl = '0; rd = '0; taken = 0; ack = 0;
        m_st = 0; m_cnt = 0; m_inst = 0; m_cause = 0;
        @(negedge clk);
        do_reset();
        chk("reset_state", 64'(state_o), 64'd0);
        chk("reset_instret", 64'(instret_o), 64'd0);

        // addi x1: 4 cycles
        set_op(I_ARI, 5'd1);
        step(1, 0, "addi_fetch"); step(0, 1, "addi_decode"); step(0, 2, "addi_exec");
        ack = 0; settle();
        chk("addi_wb_state", 64'(state_o), 64'd4);
        chk("addi_rf_we", 64'(rf_we_o), 64'd1);
        chk("addi_wb_sel", 64'(wb_sel_o), 64'd0);
        chk("addi_pc_sel", 64'(pc_sel_o), 64'd0);
        tick();
        chk("addi_instret", 64'(instret_o), 64'd1);

        // lw x2 with data ack two cycles late: 7 cycles
        set_op(I_LD, 5'd2);
        step(1, 0, "lw_fetch"); step(0, 1, "lw_decode"); step(0, 2, "lw_exec");
        for (int i = 0; i < 3; i++) begin
            ack = (i == 2); settle();
            chk("lw_mem_state", 64'(state_o), 64'd3);
            chk("lw_mem_we", 64'(mem_we_o), 64'd0);
            chk("lw_dr_we", 64'(dr_we_o), 64'(i == 2));
            tick();
        end
        ack = 0; settle();
        chk("lw_wb_sel", 64'(wb_sel_o), 64'd1);
        tick();
        chk("lw_instret", 64'(instret_o), 64'd2);

        // beq taken, then not taken
        for (int t = 1; t >= 0; t--) begin
            set_op(I_BR, 5'd7); taken = 1'(t);
            step(1, 0, "beq_fetch"); step(0, 1, "beq_decode");
            ack = 0; settle();
            chk("beq_pc_sel", 64'(pc_sel_o), 64'(t));
            chk("beq_rf_we", 64'(rf_we_o), 64'd0);
            tick();
        end
        chk("beq_instret", 64'(instret_o), 64'd4);

        // illegal all-zero instruction
        set_op(-1, 5'd0);
        step(1, 0, "ill_fetch"); step(0, 1, "ill_decode");
        for (int i = 0; i < 3; i++) begin
            ack = 1'(i); settle();
            chk("ill_trap", 64'(trap_o), 64'd1);
            chk("ill_cause", 64'(trap_cause_o), 64'd1);
            chk("ill_instret", 64'(instret_o), 64'd4);
            tick();
        end
        do_reset();

        // ebreak: sticky halt, strobes idle
        set_op(I_EBC, 5'd0);
        step(1, 0, "ebc_fetch"); step(0, 1, "ebc_decode");
        for (int i = 0; i < 20; i++) begin
            ack = 1'($urandom_range(0, 1)); settle();
            chk("ebc_halted", 64'(halted_o), 64'd1);
            chk("ebc_strobes", 64'({mem_req_o, mem_we_o, ir_we_o, dr_we_o, pc_we_o, rf_we_o}), 64'd0);
            tick();
        end
        do_reset();

        // fetch timeout with no ack
        set_op(I_ARI, 5'd3);
        for (int i = 0; i < TO; i++) step(0, 0, "to_fetch_wait");
        ack = 0; settle();
        chk("to_trap_state", 64'(state_o), 64'd6);
        chk("to_trap_cause", 64'(trap_cause_o), 64'd2);
        tick();
        do_reset();

        // ack on the limit cycle wins
        for (int i = 0; i < TO - 1; i++) step(0, 0, "to_ack_wait");
        step(1, 0, "to_ack_last");
        step(0, 1, "to_ack_decode");
        step(0, 2, "to_ack_exec");
        step(0, 4, "to_ack_wb");

        // reset during a store wait drops the request immediately
        set_op(I_ST, 5'd0);
        step(1, 0, "rst_fetch"); step(0, 1, "rst_decode"); step(0, 2, "rst_exec");
        ack = 0; settle();
        chk("rst_mem_req_before", 64'(mem_req_o), 64'd1);
        chk("rst_mem_we_before", 64'(mem_we_o), 64'd1);
        tick();
        rst = 1; settle();
        chk("rst_mem_req_drop", 64'(mem_req_o), 64'd0);
        tick();
        rst = 0; settle();
        chk("rst_after_state", 64'(state_o), 64'd0);
        chk("rst_after_instret", 64'(instret_o), 64'd0);
        chk("rst_after_trap", 64'(trap_o), 64'd0);
        tick();

        // randomized instruction stream
        stuck = 0;
        for (int c = 0; c < 4000; c++) begin
            if (m_st == 0) begin
                r = $urandom_range(0, 39);
                if (r < 36)      set_op(r % 9, 5'($urandom_range(0, 31)));
                else if (r < 38) set_op(I_EBC, 5'd0);
                else             set_op(-1, 5'd0);
                if ($urandom_range(0, 7) == 0) rd = 5'd0;
            end
            taken = 1'($urandom_range(0, 1));
            if (m_st == 0 || m_st == 3) ack = ($urandom_range(0, 2) != 0);
            else                        ack = ($urandom_range(0, 3) == 0);
            stuck = (m_st >= 5) ? stuck + 1 : 0;
            rst = (stuck > 3) || ($urandom_range(0, 499) == 0);
            settle();
            tick();
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
